mod_add_pipe: RTL and testbench
===============================

// Module: mod_add_pipe
// PURPOSE
//   Pipelined modular adder for the Kyber NTT datapath. Computes (in1+in2) mod Q,
//   optionally halved mod Q (DIV_2). It is the addition-side counterpart of the
//   modular subtractor in the butterfly unit.
//   Adds valid/ready flow control, so it can sit between the coefficient RAM
//   reader and the butterfly writer with backpressure.
// PARAMETERS
//   W       12    coefficient width
//   Q       3329  modulus; inputs must lie in [0,Q-1]
//   HALF_Q  1665  (Q+1)/2, the halving correction term
// PORTS
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous, active-low reset
//   in_valid   in   1  operand beat valid
//   in_ready   out  1  block can accept a beat this cycle
//   mode       in   2  0=NORMAL, 1=DIV_2, 2/3 reserved (behave as NORMAL)
//   in1        in   W  operand a, < Q
//   in2        in   W  operand b, < Q
//   out_valid  out  1  result beat valid
//   out_ready  in   1  downstream accepts result
//   res        out  W  result, always < Q
// BEHAVIOUR
//   - Reset (async assert, sync-safe release): all pipeline valids=0, res=0,
//     stored modes=NORMAL, out_valid=0. in_ready=1 while reset is deasserted.
//   - Pipeline has 2 register stages, S1 and S2. Each stage holds {valid, mode, data}.
//   - S1 captures on an accepted beat (in_valid & in_ready):
//       sum = in1 + in2 (13 bits; maximum 6656 < 2Q)
//       r1  = (sum >= Q) ? sum - Q : sum
//   - S2 loads from S1. DIV_2: r1 odd -> (r1>>1)+HALF_Q; r1 even -> r1>>1.
//     NORMAL/reserved: r1.
//   - res is the S2 data register. out_valid is the S2 valid bit.
//   - Latency: an accepted beat appears with out_valid 2 cycles later, if not stalled.
//   - Mode travels with its data, so mode changes beat-to-beat are legal.
//   - Advance rules:
//       adv2     = out_ready | ~v2
//       adv1     = adv2 | ~v1
//       in_ready = adv1 (combinational from out_ready; this path is allowed)
//   - Stage update rules:
//       adv1: S1 <= incoming beat, or bubble if no handshake.
//       adv2: S2 <= S1.
//       Otherwise the stage holds its contents.
//   - While out_valid=1 and out_ready=0, res and out_valid stay stable.
//   - Full pipe (v1=v2=1) with out_ready=0: in_ready=0. No beat is lost or duplicated.
//   - Simultaneous drain and accept in one cycle is allowed; throughput is 1 beat/cycle.
//   - Order is strictly FIFO.
//   - Reset mid-operation: all in-flight beats are discarded; out_valid=0 immediately.
//   - Inputs >= Q: result is unspecified but still W bits wide. The bench must not drive them.
//   - in1, in2 and mode are sampled only on a handshake.
// STRUCTURE
//   - Shared package kyber_pkg holds: Q, HALF_Q, W, and the mode constants
//     MODE_NORMAL=2'd0, MODE_DIV2=2'd1 (shared with the subtractor).
//   - One natural sub-module: mod_half (combinational r -> r/2 mod Q), reusable by
//     the subtractor. Everything else is inline.
// TESTING
//   1. NORMAL: 3328+1 -> 0; 3000+1000 -> 671; 0+0 -> 0. Each has 2-cycle latency
//      with out_ready=1.
//   2. DIV_2: 1+2 -> 1666; 4+6 -> 5; 3328+3328 (r1=3327) -> 3328. Reserved mode 3
//      with 5+5 -> 10.
//   3. Streaming: 100 back-to-back random beats with mixed modes and out_ready=1
//      -> in_ready stays 1 and results match the golden model in order.
//   4. Backpressure: out_ready=0 for 6 cycles while offering 4 beats -> exactly
//      2 accepted and in_ready=0. res holds stable. On release, 4 results arrive
//      in order with no duplicates.
//   5. Random out_ready toggling (50%) over 1000 beats -> scoreboard matches and
//      no drop or duplicate.
//   6. Assert rst_n=0 with 2 beats in flight -> out_valid=0 asynchronously.
//      After release, the first new beat emerges after 2 cycles and no stale data appears.

Source files
------------

// File: rtl/kyber_pkg.sv
// Shared constants for the Kyber NTT modular arithmetic units (adder and subtractor).
package kyber_pkg;
  localparam int W      = 12;
  localparam int Q      = 3329;
  localparam int HALF_Q = 1665;

  localparam logic [1:0] MODE_NORMAL = 2'd0;
  localparam logic [1:0] MODE_DIV2   = 2'd1;
endpackage

// File: rtl/mod_half.sv
// Combinational halving modulo Q: r -> r * 2^-1 mod Q, for r in [0, Q-1].
module mod_half
  import kyber_pkg::*;
(
  input  logic [W-1:0] r_i,
  output logic [W-1:0] half_o
);

  logic [W-1:0] shr;

  assign shr = {1'b0, r_i[W-1:1]};

  // An odd r becomes (r + Q) / 2, which is (r >> 1) + (Q + 1) / 2.
  always_comb begin
    half_o = shr;
    if (r_i[0]) begin
      half_o = W'(int'(shr) + HALF_Q);
    end
  end

endmodule

// File: rtl/mod_add_pipe.sv
// Two-stage pipelined modular adder (a + b) mod Q, with optional halving and valid/ready flow.
module mod_add_pipe
  import kyber_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   mode,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] res
);

  localparam logic [W:0] Q_EXT = (W+1)'(Q);

  logic         v1_q, v1_d, v2_q, v2_d;
  logic [1:0]   m1_q, m1_d;
  logic [W-1:0] d1_q, d1_d, d2_q, d2_d;
  logic         adv1, adv2;
  logic [W:0]   sum;
  logic [W-1:0] half;

  assign adv2     = out_ready | ~v2_q;
  assign adv1     = adv2 | ~v1_q;
  assign in_ready = adv1;

  assign sum = {1'b0, in1} + {1'b0, in2};

  mod_half u_half (
    .r_i    (d1_q),
    .half_o (half)
  );

  always_comb begin
    v1_d = v1_q;
    m1_d = m1_q;
    d1_d = d1_q;
    v2_d = v2_q;
    d2_d = d2_q;
    if (adv1) begin
      v1_d = in_valid;
      if (in_valid) begin
        m1_d = mode;
        d1_d = (sum >= Q_EXT) ? W'(sum - Q_EXT) : W'(sum);
      end
    end
    // Reserved modes fall through to the plain sum.
    if (adv2) begin
      v2_d = v1_q;
      if (v1_q) begin
        d2_d = (m1_q == MODE_DIV2) ? half : d1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      m1_q <= MODE_NORMAL;
      d1_q <= '0;
      v2_q <= 1'b0;
      d2_q <= '0;
    end else begin
      v1_q <= v1_d;
      m1_q <= m1_d;
      d1_q <= d1_d;
      v2_q <= v2_d;
      d2_q <= d2_d;
    end
  end

  assign out_valid = v2_q;
  assign res       = d2_q;

endmodule

// File: tb/tb_mod_add_pipe.sv
// Self-checking bench for mod_add_pipe: literal vectors, random streaming, backpressure, reset.
module tb_mod_add_pipe;
  import kyber_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] res;

  mod_add_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int n_in  = 0;
  int n_out = 0;
  logic [W-1:0] exp_q[$];
  logic         stall_q = 1'b0;
  logic [W-1:0] stall_res = '0;

  // Reference: plain modular arithmetic; halving is multiplication by the inverse of 2.
  function automatic logic [W-1:0] model(input int a, input int b, input int m);
    int s;
    s = (a + b) % Q;
    if (m == 1) s = (s % 2 == 1) ? (s + Q) / 2 : s / 2;
    return W'(s);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("hold_valid", 32'(out_valid), 1);
        check("hold_res", 32'(res), 32'(stall_res));
      end
      if (out_valid) check("res_range", 32'(res < W'(Q)), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got res %0d, expected no output", res);
        end else begin
          check("scoreboard", 32'(res), 32'(exp_q.pop_front()));
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(int'(in1), int'(in2), int'(mode)));
        n_in++;
      end
      stall_q   = out_valid && !out_ready;
      stall_res = res;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_check(input string name, input int a, input int b, input int m,
                            input int exp);
    check({name, "_model"}, 32'(model(a, b, m)), 32'(exp));
    in1 = W'(a);
    in2 = W'(b);
    mode = 2'(m);
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check({name, "_ready"}, 32'(in_ready), 1);
    cyc();
    in_valid = 1'b0;
    check({name, "_lat1"}, 32'(out_valid), 0);
    cyc();
    check({name, "_valid"}, 32'(out_valid), 1);
    check({name, "_res"}, 32'(res), 32'(exp));
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 20) begin
      cyc();
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  task automatic new_beat();
    in1  = W'($urandom_range(0, Q - 1));
    in2  = W'($urandom_range(0, Q - 1));
    mode = 2'($urandom_range(0, 3));
  endtask

  task automatic run_beats(input int nbeats, input int bp_pct, input bit check_ready);
    int acc;
    int cycles;
    bit hs;
    acc = 0;
    cycles = 0;
    new_beat();
    in_valid = 1'b1;
    while (acc < nbeats && cycles < nbeats * 20) begin
      out_ready = (bp_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= bp_pct);
      @(negedge clk);
      if (check_ready) check("stream_ready", 32'(in_ready), 1);
      hs = in_valid && in_ready;
      cyc();
      cycles++;
      if (hs) acc++;
      if (hs || !in_valid) begin
        new_beat();
        in_valid = (bp_pct == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
    end
    in_valid = 1'b0;
    check("beats_accepted", 32'(acc), 32'(nbeats));
  endtask

  initial begin
    int acc;
    int idx;
    int base;
    int n;
    logic [W-1:0] bp_a[4];
    logic [W-1:0] bp_b[4];

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    #2;
    rst_n = 1'b1;
    #1;
    check("rst_res", 32'(res), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    cyc();

    send_check("n_wrap", 3328, 1, 0, 0);
    send_check("n_big", 3000, 1000, 0, 671);
    send_check("n_zero", 0, 0, 0, 0);
    send_check("d_odd", 1, 2, 1, 1666);
    send_check("d_even", 4, 6, 1, 5);
    send_check("d_max", 3328, 3328, 1, 3328);
    send_check("rsv3", 5, 5, 3, 10);
    drain();

    run_beats(100, 0, 1'b1);
    drain();

    for (int i = 0; i < 4; i++) begin
      bp_a[i] = W'($urandom_range(0, Q - 1));
      bp_b[i] = W'($urandom_range(0, Q - 1));
    end
    base = n_out;
    acc = 0;
    idx = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (6) begin
      in1 = bp_a[idx];
      in2 = bp_b[idx];
      mode = 2'(idx % 2);
      @(negedge clk);
      if (in_ready) begin
        acc++;
        idx++;
      end
      cyc();
    end
    check("bp_accepted", 32'(acc), 2);
    check("bp_in_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    n = 0;
    while (idx < 4 && n < 20) begin
      in1 = bp_a[idx];
      in2 = bp_b[idx];
      mode = 2'(idx % 2);
      @(negedge clk);
      if (in_ready) idx++;
      cyc();
      n++;
    end
    in_valid = 1'b0;
    n = 0;
    while (n_out < base + 4 && n < 20) begin
      cyc();
      n++;
    end
    check("bp_results", 32'(n_out - base), 4);
    drain();

    run_beats(1000, 50, 1'b0);
    drain();
    check("count_in_out", 32'(n_in), 32'(n_out));

    in1 = 12'd10;
    in2 = 12'd20;
    mode = 2'd0;
    in_valid = 1'b1;
    cyc();
    in1 = 12'd30;
    in2 = 12'd40;
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    check("inflight_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    cyc();
    check("post_rst_valid", 32'(out_valid), 0);
    check("post_rst_res", 32'(res), 0);
    check("post_rst_queue", 32'(exp_q.size()), 0);
    send_check("post_rst", 1234, 2345, 0, 250);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
